// File: rtl/crc_pkg.sv
// Shared types and constants for the CRC stream engine: FSM state encoding,
// result length width, named generator polynomials and a byte reflection helper.
package crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int unsigned LEN_W = 16;

  localparam logic [4:0]  CRC5_USB    = 5'h05;
  localparam logic [15:0] CRC16       = 16'h8005;
  localparam logic [15:0] CRC16_CCITT = 16'h1021;
  localparam logic [31:0] CRC32       = 32'h04C11DB7;

  function automatic logic [7:0] reflect8(input logic [7:0] b);
    logic [7:0] w_src;
    logic [7:0] w_dst;
    w_src = b;
    w_dst = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w_dst = {w_dst[6:0], w_src[0]};
      w_src = w_src >> 1;
    end
    return w_dst;
  endfunction

endpackage

// File: rtl/crc_stream_engine_if.sv
// Stream-in / result-out handshake bundle for crc_stream_engine.
interface crc_stream_engine_if
  import crc_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CRC_W  = 16
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic [CRC_W-1:0]  in_exp;
  logic              abort;
  logic              out_valid;
  logic              out_ready;
  logic [CRC_W-1:0]  out_crc;
  logic              out_ok;
  logic [LEN_W-1:0]  out_len;

  modport master (
    output in_valid, in_data, in_last, in_exp, abort, out_ready,
    input  in_ready, out_valid, out_crc, out_ok, out_len
  );

  modport slave (
    input  in_valid, in_data, in_last, in_exp, abort, out_ready,
    output in_ready, out_valid, out_crc, out_ok, out_len
  );

endinterface

// File: rtl/crc_stream_engine_step.sv
// Combinational CRC update over one beat: bytes taken LSB-byte first, each
// optionally bit-reflected, then shifted MSB-first through the normal-form register.
module crc_step
  import crc_pkg::*;
#(
  parameter int unsigned      DATA_W = 8,
  parameter int unsigned      CRC_W  = 16,
  parameter logic [CRC_W-1:0] POLY   = CRC16,
  parameter bit               REFIN  = 1'b1
) (
  input  logic [CRC_W-1:0]  i_crc,
  input  logic [DATA_W-1:0] i_data,
  output logic [CRC_W-1:0]  o_crc
);

  always_comb begin
    logic [CRC_W-1:0]  w_crc;
    logic [DATA_W-1:0] w_data;
    logic [7:0]        w_byte;
    logic              w_fb;
    w_crc  = i_crc;
    w_data = i_data;
    w_byte = '0;
    w_fb   = 1'b0;
    for (int unsigned b = 0; b < DATA_W / 8; b++) begin
      w_byte = REFIN ? reflect8(w_data[7:0]) : w_data[7:0];
      w_data = w_data >> 8;
      for (int unsigned k = 0; k < 8; k++) begin
        w_fb   = w_crc[CRC_W-1] ^ w_byte[7];
        w_byte = w_byte << 1;
        w_crc  = {w_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
      end
    end
    o_crc = w_crc;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Framed CRC engine: accumulates a CRC over a beat stream and holds one
// registered result (CRC, match flag, beat count) until the consumer takes it.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int unsigned      DATA_W = 8,
  parameter int unsigned      CRC_W  = 16,
  parameter logic [CRC_W-1:0] POLY   = CRC16,
  parameter logic [CRC_W-1:0] INIT   = '1,
  parameter bit               REFIN  = 1'b1,
  parameter bit               REFOUT = 1'b1,
  parameter logic [CRC_W-1:0] XOROUT = '0
) (
  input  logic               clk,
  input  logic               rst,
  crc_stream_engine_if.slave bus
);

  state_e           r_state;
  logic [CRC_W-1:0] r_crc;
  logic [LEN_W-1:0] r_len;
  logic             r_out_valid;
  logic [CRC_W-1:0] r_out_crc;
  logic             r_out_ok;
  logic [LEN_W-1:0] r_out_len;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_abort;
  logic             w_start;
  logic [CRC_W-1:0] w_base;
  logic [CRC_W-1:0] w_next;
  logic [CRC_W-1:0] w_refl;
  logic [CRC_W-1:0] w_final;
  logic [LEN_W-1:0] w_len_next;

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_abort    = bus.abort && (r_state == ST_RUN);
  // Any beat accepted outside RUN opens a fresh frame, including the one that
  // arrives in the same cycle a held result is consumed.
  assign w_start    = (r_state != ST_RUN);
  assign w_base     = w_start ? INIT : r_crc;
  assign w_len_next = w_start ? LEN_W'(1) :
                      ((r_len == '1) ? r_len : r_len + LEN_W'(1));

  crc_step #(
    .DATA_W (DATA_W),
    .CRC_W  (CRC_W),
    .POLY   (POLY),
    .REFIN  (REFIN)
  ) u_step (
    .i_crc  (w_base),
    .i_data (bus.in_data),
    .o_crc  (w_next)
  );

  always_comb begin
    logic [CRC_W-1:0] w_src;
    w_src  = w_next;
    w_refl = '0;
    for (int unsigned i = 0; i < CRC_W; i++) begin
      w_refl = {w_refl[CRC_W-2:0], w_src[0]};
      w_src  = w_src >> 1;
    end
  end

  assign w_final = (REFOUT ? w_refl : w_next) ^ XOROUT;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_crc       <= INIT;
      r_len       <= '0;
      r_out_valid <= 1'b0;
      r_out_crc   <= '0;
      r_out_ok    <= 1'b0;
      r_out_len   <= '0;
    end else if (w_abort) begin
      r_state <= ST_IDLE;
      r_crc   <= INIT;
    end else if (w_accept) begin
      r_crc <= w_next;
      r_len <= w_len_next;
      if (bus.in_last) begin
        r_state     <= ST_HOLD;
        r_out_valid <= 1'b1;
        r_out_crc   <= w_final;
        r_out_ok    <= (w_final == bus.in_exp);
        r_out_len   <= w_len_next;
      end else begin
        r_state     <= ST_RUN;
        r_out_valid <= 1'b0;
      end
    end else if (r_out_valid && bus.out_ready) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_crc   = r_out_crc;
  assign bus.out_ok    = r_out_ok;
  assign bus.out_len   = r_out_len;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Self-checking bench for crc_stream_engine: default CRC-16 instance plus a
// 5-bit instance, checked against a reflected bytewise reference model.
module tb_crc_stream_engine;

  typedef logic [7:0] bq_t[$];

  logic clk;
  logic rst;
  int   total;
  int   bad;

  crc_stream_engine_if #(.DATA_W(8), .CRC_W(16)) b16 ();
  crc_stream_engine_if #(.DATA_W(8), .CRC_W(5))  b5 ();

  crc_stream_engine u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b16.slave)
  );

  crc_stream_engine #(
    .DATA_W (8),
    .CRC_W  (5),
    .POLY   (crc_pkg::CRC5_USB),
    .INIT   (5'h1F),
    .XOROUT (5'h1F)
  ) u_dut5 (
    .clk (clk),
    .rst (rst),
    .bus (b5.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reflected (LSB-first) formulation: reflected poly and init, byte XOR into the low end.
  function automatic logic [31:0] ref_crc(input bq_t bytes, input int unsigned w,
                                          input logic [31:0] poly, input logic [31:0] init,
                                          input logic [31:0] xorout);
    logic [31:0] rp, ri, t, c, mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    rp = '0; ri = '0; t = poly; c = init;
    repeat (w) begin
      rp = (rp << 1) | (t & 32'd1);
      ri = (ri << 1) | (c & 32'd1);
      t  = t >> 1;
      c  = c >> 1;
    end
    c = ri;
    foreach (bytes[i]) begin
      c = c ^ {24'd0, bytes[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ rp) : (c >> 1);
    end
    return (c ^ xorout) & mask;
  endfunction

  function automatic logic [31:0] ref16(input bq_t bytes);
    return ref_crc(bytes, 16, 32'h8005, 32'hFFFF, 32'h0);
  endfunction

  function automatic bq_t check_string();
    bq_t q;
    for (int i = 0; i < 9; i++) q.push_back(8'(8'h31 + i));
    return q;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send16(input bq_t bytes, input logic [15:0] exp);
    for (int i = 0; i < bytes.size(); i++) begin
      b16.in_valid = 1'b1;
      b16.in_data  = bytes[i];
      b16.in_last  = (i == bytes.size() - 1);
      b16.in_exp   = exp;
      tick();
    end
    b16.in_valid = 1'b0;
    b16.in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    b16.in_valid = 1'b0; b16.in_data = '0; b16.in_last = 1'b0; b16.in_exp = '0;
    b16.abort = 1'b0; b16.out_ready = 1'b0;
    b5.in_valid = 1'b0; b5.in_data = '0; b5.in_last = 1'b0; b5.in_exp = '0;
    b5.abort = 1'b0; b5.out_ready = 1'b0;
    #12;
    total++; if (b16.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", b16.out_valid); end
    total++; if (b16.in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", b16.in_ready); end
    total++; if (b16.out_crc !== 16'h0) begin bad++; $display("FAIL rst_crc got=%h want=0000", b16.out_crc); end
    total++; if (b16.out_ok !== 1'b0) begin bad++; $display("FAIL rst_ok got=%b want=0", b16.out_ok); end
    total++; if (b16.out_len !== 16'h0) begin bad++; $display("FAIL rst_len got=%0d want=0", b16.out_len); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_check_string();
    bq_t s;
    logic [31:0] m;
    s = check_string();
    m = ref16(s);
    b16.out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      b16.in_valid = 1'b1; b16.in_data = s[i]; b16.in_last = (i == 8); b16.in_exp = 16'h4B37;
      tick();
      if (i < 8) begin
        total++; if (b16.out_valid !== 1'b0) begin bad++; $display("FAIL str_early_valid beat=%0d got=%b want=0", i, b16.out_valid); end
      end
    end
    b16.in_valid = 1'b0; b16.in_last = 1'b0;
    total++; if (b16.out_valid !== 1'b1) begin bad++; $display("FAIL str_valid got=%b want=1", b16.out_valid); end
    total++; if (b16.out_crc !== 16'h4B37) begin bad++; $display("FAIL str_crc got=%h want=4b37", b16.out_crc); end
    total++; if (b16.out_crc !== m[15:0]) begin bad++; $display("FAIL str_crc_model got=%h want=%h", b16.out_crc, m[15:0]); end
    total++; if (b16.out_len !== 16'd9) begin bad++; $display("FAIL str_len got=%0d want=9", b16.out_len); end
    total++; if (b16.out_ok !== 1'b1) begin bad++; $display("FAIL str_ok got=%b want=1", b16.out_ok); end
    b16.out_ready = 1'b1;
    tick();
    b16.out_ready = 1'b0;
    total++; if (b16.out_valid !== 1'b0) begin bad++; $display("FAIL str_drop got=%b want=0", b16.out_valid); end
  endtask

  task automatic test_crc5();
    bq_t s;
    logic [31:0] m;
    s = check_string();
    m = ref_crc(s, 5, 32'h05, 32'h1F, 32'h1F);
    for (int i = 0; i < 9; i++) begin
      b5.in_valid = 1'b1; b5.in_data = s[i]; b5.in_last = (i == 8); b5.in_exp = 5'h19;
      tick();
    end
    b5.in_valid = 1'b0; b5.in_last = 1'b0;
    total++; if (b5.out_valid !== 1'b1) begin bad++; $display("FAIL c5_valid got=%b want=1", b5.out_valid); end
    total++; if (b5.out_crc !== 5'h19) begin bad++; $display("FAIL c5_crc got=%h want=19", b5.out_crc); end
    total++; if (b5.out_crc !== m[4:0]) begin bad++; $display("FAIL c5_crc_model got=%h want=%h", b5.out_crc, m[4:0]); end
    total++; if (b5.out_len !== 16'd9) begin bad++; $display("FAIL c5_len got=%0d want=9", b5.out_len); end
    b5.out_ready = 1'b1;
    tick();
    b5.out_ready = 1'b0;
  endtask

  task automatic test_hold();
    b16.out_ready = 1'b0;
    b16.in_valid = 1'b1; b16.in_data = 8'h00; b16.in_last = 1'b1; b16.in_exp = 16'h40BF;
    tick();
    b16.in_data = 8'hA5;
    for (int c = 0; c < 5; c++) begin
      #2;
      total++; if (b16.in_ready !== 1'b0) begin bad++; $display("FAIL hold_ready cyc=%0d got=%b want=0", c, b16.in_ready); end
      total++; if (b16.out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid cyc=%0d got=%b want=1", c, b16.out_valid); end
      total++; if (b16.out_crc !== 16'h40BF) begin bad++; $display("FAIL hold_crc cyc=%0d got=%h want=40bf", c, b16.out_crc); end
      total++; if (b16.out_ok !== 1'b1) begin bad++; $display("FAIL hold_ok cyc=%0d got=%b want=1", c, b16.out_ok); end
      total++; if (b16.out_len !== 16'd1) begin bad++; $display("FAIL hold_len cyc=%0d got=%0d want=1", c, b16.out_len); end
      tick();
    end
    b16.in_valid = 1'b0; b16.in_last = 1'b0; b16.out_ready = 1'b1;
    tick();
    b16.out_ready = 1'b0;
    total++; if (b16.out_valid !== 1'b0) begin bad++; $display("FAIL hold_release got=%b want=0", b16.out_valid); end
  endtask

  task automatic test_back_to_back();
    bq_t one;
    logic [31:0] m;
    logic [15:0] e;
    b16.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      one = {};
      one.push_back(8'($urandom));
      m = ref16(one);
      e = ($urandom_range(0, 1) == 1) ? m[15:0] : 16'($urandom);
      b16.in_valid = 1'b1; b16.in_data = one[0]; b16.in_last = 1'b1; b16.in_exp = e;
      #2;
      total++; if (b16.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready k=%0d got=%b want=1", k, b16.in_ready); end
      tick();
      total++; if (b16.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid k=%0d got=%b want=1", k, b16.out_valid); end
      total++; if (b16.out_crc !== m[15:0]) begin bad++; $display("FAIL b2b_crc k=%0d got=%h want=%h", k, b16.out_crc, m[15:0]); end
      total++; if (b16.out_ok !== (e == m[15:0])) begin bad++; $display("FAIL b2b_ok k=%0d got=%b want=%b", k, b16.out_ok, (e == m[15:0])); end
      total++; if (b16.out_len !== 16'd1) begin bad++; $display("FAIL b2b_len k=%0d got=%0d want=1", k, b16.out_len); end
    end
    b16.in_valid = 1'b0; b16.in_last = 1'b0;
    tick();
    b16.out_ready = 1'b0;
    total++; if (b16.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b want=0", b16.out_valid); end
  endtask

  task automatic test_abort();
    bq_t junk;
    for (int i = 0; i < 4; i++) junk.push_back(8'($urandom));
    junk.push_back(8'h00);
    b16.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b16.in_valid = 1'b1; b16.in_data = junk[i]; b16.in_last = 1'b0;
      tick();
    end
    b16.abort = 1'b1; b16.in_valid = 1'b1; b16.in_data = 8'($urandom); b16.in_last = 1'b1;
    tick();
    b16.abort = 1'b0; b16.in_valid = 1'b0; b16.in_last = 1'b0; b16.out_ready = 1'b0;
    total++; if (b16.out_valid !== 1'b0) begin bad++; $display("FAIL abort_ignored got=%b want=0", b16.out_valid); end
    send16(check_string(), 16'h4B37);
    total++; if (b16.out_crc !== 16'h4B37) begin bad++; $display("FAIL abort_crc got=%h want=4b37", b16.out_crc); end
    total++; if (b16.out_len !== 16'd9) begin bad++; $display("FAIL abort_len got=%0d want=9", b16.out_len); end
    b16.abort = 1'b1;
    tick();
    b16.abort = 1'b0;
    total++; if (b16.out_valid !== 1'b1) begin bad++; $display("FAIL abort_hold_valid got=%b want=1", b16.out_valid); end
    total++; if (b16.out_crc !== 16'h4B37) begin bad++; $display("FAIL abort_hold_crc got=%h want=4b37", b16.out_crc); end
    b16.out_ready = 1'b1;
    tick();
    b16.out_ready = 1'b0;
  endtask

  task automatic test_reset_midframe();
    bq_t one;
    one.push_back(8'h5A);
    send16(one, 16'h0);
    total++; if (b16.out_valid !== 1'b1) begin bad++; $display("FAIL rsthold_pre got=%b want=1", b16.out_valid); end
    #2 rst = 1'b0;
    #1;
    total++; if (b16.out_valid !== 1'b0) begin bad++; $display("FAIL rsthold_valid got=%b want=0", b16.out_valid); end
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      b16.in_valid = 1'b1; b16.in_data = 8'($urandom); b16.in_last = 1'b0;
      tick();
    end
    #2 rst = 1'b0;
    #1;
    total++; if (b16.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", b16.out_valid); end
    total++; if (b16.in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", b16.in_ready); end
    b16.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    send16(check_string(), 16'h4B37);
    total++; if (b16.out_crc !== 16'h4B37) begin bad++; $display("FAIL rstmid_crc got=%h want=4b37", b16.out_crc); end
    total++; if (b16.out_len !== 16'd9) begin bad++; $display("FAIL rstmid_len got=%0d want=9", b16.out_len); end
    b16.out_ready = 1'b1;
    tick();
    b16.out_ready = 1'b0;
  endtask

  task automatic test_random_frames();
    bq_t f;
    logic [31:0] m;
    logic [15:0] e;
    int n;
    for (int k = 0; k < 10; k++) begin
      f = {};
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) f.push_back(8'($urandom));
      m = ref16(f);
      e = ($urandom_range(0, 1) == 1) ? m[15:0] : 16'($urandom);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) begin
          b16.in_valid = 1'b0; b16.in_data = 8'($urandom);
          tick();
        end
        b16.in_valid = 1'b1; b16.in_data = f[i]; b16.in_last = (i == n - 1); b16.in_exp = e;
        tick();
      end
      b16.in_valid = 1'b0; b16.in_last = 1'b0;
      repeat ($urandom_range(1, 3)) begin
        total++; if (b16.out_valid !== 1'b1) begin bad++; $display("FAIL rnd_valid k=%0d got=%b want=1", k, b16.out_valid); end
        total++; if (b16.out_crc !== m[15:0]) begin bad++; $display("FAIL rnd_crc k=%0d got=%h want=%h", k, b16.out_crc, m[15:0]); end
        total++; if (b16.out_len !== 16'(n)) begin bad++; $display("FAIL rnd_len k=%0d got=%0d want=%0d", k, b16.out_len, n); end
        total++; if (b16.out_ok !== (e == m[15:0])) begin bad++; $display("FAIL rnd_ok k=%0d got=%b want=%b", k, b16.out_ok, (e == m[15:0])); end
        tick();
      end
      b16.out_ready = 1'b1;
      tick();
      b16.out_ready = 1'b0;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_check_string();
    test_crc5();
    test_hold();
    test_back_to_back();
    test_abort();
    test_reset_midframe();
    test_random_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
